// File: rtl/score_display.sv
// score_display: scans a 4-digit 7-segment display showing the live score
//   (re-sampled once per frame) and the best score seen since reset.
// Latency: seg/an are registered and change on the scan-advance edge; best
//   loads on the frame-start edge and is visible right after it.
// Backpressure: none; the scan is free-running and the inputs are sampled.
//
// Ports:
//   clock       single system clock, rising edge
//   reset       synchronous, active-high
//   score       BCD units of the live score
//   score10     BCD tens of the live score
//   seg[6:0]    segment drive, seg[0]=a .. seg[6]=g (polarity per ACTIVE_LOW)
//   an[3:0]     one-hot digit enable: 0=score, 1=score10, 2=best, 3=best10
//   best        BCD units of the best score held
//   best10      BCD tens of the best score held
//   frame_tick  one-cycle pulse in the first cycle of each frame
//
// Build option: define SCORE_DISPLAY_BLINK_EN to blink digits 0-1 on
//   alternate frames for 16 frames after the snapshot changes.

module score_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] score,
  input  logic [3:0] score10,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [3:0] best,
  output logic [3:0] best10,
  output logic       frame_tick
);

  localparam int               DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  // Active-high g..a patterns; any non-decimal nibble shows a dash.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  function automatic logic [6:0] seg_drive(input logic [6:0] p);
    return ACTIVE_LOW ? ~p : p;
  endfunction

  function automatic logic [3:0] an_drive(input logic [3:0] h);
    return ACTIVE_LOW ? ~h : h;
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       scan_idx;
  logic [1:0]       scan_idx_nxt;
  logic [3:0]       snap_u;
  logic [3:0]       snap_t;
  logic [3:0]       snap_u_nxt;
  logic [3:0]       snap_t_nxt;
  logic             div_last;
  logic             frame_wrap;
  logic             in_valid;
  logic             best_load;
  logic             blank_live;
  logic [6:0]       seg_nxt_pat;
  logic [3:0]       an_nxt_hot;

  always_comb begin
    div_last     = (div_cnt == DIV_LAST);
    frame_wrap   = div_last && (scan_idx == 2'd3);
    scan_idx_nxt = scan_idx + 2'd1;
    // The digit-0 pattern chosen on the wrap edge must already reflect the
    // value being snapshotted on that same edge.
    snap_u_nxt   = frame_wrap ? score   : snap_u;
    snap_t_nxt   = frame_wrap ? score10 : snap_t;
    in_valid     = (score <= 4'd9) && (score10 <= 4'd9);
    // With both sides valid BCD, the packed compare equals the decimal one.
    best_load    = frame_wrap && in_valid && ({score10, score} > {best10, best});
  end

`ifdef SCORE_DISPLAY_BLINK_EN
  // Frames left in the blink window. Loaded with 16 on the frame where the
  // snapshot changes and counted down once per frame; odd counts blank the
  // live digits, so the change frame itself shows the new value.
  logic [4:0] blink_left;
  logic [4:0] blink_left_nxt;
  logic       snap_changed;

  always_comb begin
    snap_changed   = frame_wrap && ({score10, score} != {snap_t, snap_u});
    blink_left_nxt = blink_left;
    if (snap_changed) begin
      blink_left_nxt = 5'd16;
    end else if (frame_wrap && (blink_left != 5'd0)) begin
      blink_left_nxt = blink_left - 5'd1;
    end
    blank_live = blink_left_nxt[0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blink_left <= 5'd0;
    end else begin
      blink_left <= blink_left_nxt;
    end
  end
`else
  always_comb begin
    blank_live = 1'b0;
  end
`endif

  // Pattern for the digit about to be selected. Best only changes on the
  // wrap edge, when digit 0 is selected, so digits 2-3 can use the register.
  always_comb begin
    an_nxt_hot  = 4'b0001 << scan_idx_nxt;
    seg_nxt_pat = 7'h00;
    case (scan_idx_nxt)
      2'd0: seg_nxt_pat = blank_live ? 7'h00 : seg_pattern(snap_u_nxt);
      2'd1: seg_nxt_pat = (blank_live || (snap_t_nxt == 4'd0)) ? 7'h00
                                                                : seg_pattern(snap_t_nxt);
      2'd2: seg_nxt_pat = seg_pattern(best);
      default: seg_nxt_pat = (best10 == 4'd0) ? 7'h00 : seg_pattern(best10);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt    <= '0;
      scan_idx   <= 2'd0;
      snap_u     <= 4'd0;
      snap_t     <= 4'd0;
      best       <= 4'd0;
      best10     <= 4'd0;
      frame_tick <= 1'b0;
      an         <= an_drive(4'b0001);
      seg        <= seg_drive(7'h3F);
    end else begin
      div_cnt    <= div_last ? '0 : div_cnt + 1'b1;
      frame_tick <= frame_wrap;
      if (div_last) begin
        scan_idx <= scan_idx_nxt;
        an       <= an_drive(an_nxt_hot);
        seg      <= seg_drive(seg_nxt_pat);
      end
      if (frame_wrap) begin
        snap_u <= score;
        snap_t <= score10;
      end
      if (best_load) begin
        best   <= score;
        best10 <= score10;
      end
    end
  end

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

    localparam int RD = 4;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] score   = 4'd0;
    logic [3:0] score10 = 4'd0;

    logic [6:0] seg, seg_al;
    logic [3:0] an, an_al;
    logic [3:0] best, best10, best_al, best10_al;
    logic       frame_tick, frame_tick_al;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    score_display #(.REFRESH_DIV(RD), .ACTIVE_LOW(1'b0)) dut (
        .clock(clock), .reset(reset), .score(score), .score10(score10),
        .seg(seg), .an(an), .best(best), .best10(best10), .frame_tick(frame_tick)
    );

    score_display #(.REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) dut_al (
        .clock(clock), .reset(reset), .score(score), .score10(score10),
        .seg(seg_al), .an(an_al), .best(best_al), .best10(best10_al),
        .frame_tick(frame_tick_al)
    );

    int m_t     = 0;
    int m_su    = 0;
    int m_st    = 0;
    int m_best  = 0;
    int m_blink = 0;
    bit m_tick  = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_t = 0; m_su = 0; m_st = 0; m_best = 0; m_blink = 0; m_tick = 1'b0;
        end else begin
            m_t    = m_t + 1;
            m_tick = 1'b0;
            if ((m_t % RD) == 0 && ((m_t / RD) % 4) == 0) begin
                m_tick = 1'b1;
                if (int'(score) != m_su || int'(score10) != m_st) m_blink = 16;
                else if (m_blink > 0) m_blink = m_blink - 1;
                m_su = int'(score);
                m_st = int'(score10);
                if (score <= 9 && score10 <= 9 && (10 * int'(score10) + int'(score)) > m_best)
                    m_best = 10 * int'(score10) + int'(score);
            end
        end
    end

    function automatic logic [6:0] ref_pat(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic int m_idx();
        return (m_t / RD) % 4;
    endfunction

    function automatic bit m_blank01();
`ifdef SCORE_DISPLAY_BLINK_EN
        return (m_blink % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [6:0] exp_seg();
        case (m_idx())
            0: return m_blank01() ? 7'h00 : ref_pat(m_su);
            1: return (m_blank01() || m_st == 0) ? 7'h00 : ref_pat(m_st);
            2: return ref_pat(m_best % 10);
            default: return (m_best / 10 == 0) ? 7'h00 : ref_pat(m_best / 10);
        endcase
    endfunction

    function automatic logic [3:0] exp_an();
        return 4'(1 << m_idx());
    endfunction

    function automatic logic [3:0] exp_b();
        return 4'(m_best % 10);
    endfunction

    function automatic logic [3:0] exp_b10();
        return 4'(m_best / 10);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag);
        n_tests++;
        if (seg !== exp_seg()) begin
            $display("FAIL %s t=%0d: seg=%h, required %h", tag, m_t, seg, exp_seg());
            n_fail++;
        end
        n_tests++;
        if (an !== exp_an()) begin
            $display("FAIL %s t=%0d: an=%b, required %b", tag, m_t, an, exp_an());
            n_fail++;
        end
        n_tests++;
        if ({best10, best} !== {exp_b10(), exp_b()}) begin
            $display("FAIL %s t=%0d: best=%0d%0d, required %0d%0d", tag, m_t,
                     best10, best, exp_b10(), exp_b());
            n_fail++;
        end
        n_tests++;
        if (frame_tick !== m_tick) begin
            $display("FAIL %s t=%0d: frame_tick=%b, required %b", tag, m_t, frame_tick, m_tick);
            n_fail++;
        end
        n_tests++;
        if ({seg_al, an_al} !== {~seg, ~an}) begin
            $display("FAIL %s t=%0d: active-low seg=%h an=%b, required %h %b", tag, m_t,
                     seg_al, an_al, ~seg, ~an);
            n_fail++;
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check_all(tag);
        end
    endtask

    task automatic wait_frame();
        int k = 0;
        do begin
            tick();
            check_all("wait_frame");
            k++;
        end while (!m_tick && k < 100);
        if (!m_tick) begin
            $display("FAIL wait_frame: no frame start after %0d cycles, required one within %0d", k, 4 * RD);
            n_fail++;
        end
    endtask

    task automatic wait_idx(input int idx, input int phase);
        int k = 0;
        while (!(m_idx() == idx && (m_t % RD) == phase) && k < 100) begin
            tick();
            check_all("wait_idx");
            k++;
        end
        if (k >= 100) begin
            $display("FAIL wait_idx: index %0d phase %0d not reached, got index %0d", idx, phase, m_idx());
            n_fail++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({an, seg, frame_tick, best10, best} !== {4'b0001, 7'h3F, 1'b0, 4'd0, 4'd0}) begin
            $display("FAIL reset: an=%b seg=%h tick=%b best=%0d%0d, required 0001 3F 0 00",
                     an, seg, frame_tick, best10, best);
            n_fail++;
        end
        reset = 1'b0;
    endtask

    initial begin
        score   = 4'd7;
        score10 = 4'd0;
        test_reset();
        run(RD - 1, "req023");
        n_tests++;
        if (an !== 4'b0001) begin
            $display("FAIL req023: an=%b before first advance, required 0001", an);
            n_fail++;
        end
        wait_frame();
        run(4 * RD, "req027");
        wait_idx(0, 1);
        n_tests++;
        if (seg !== 7'h07) begin
            $display("FAIL req027: digit 0 seg=%h, required 07", seg);
            n_fail++;
        end
        wait_idx(1, 1);
        n_tests++;
        if (seg !== 7'h00) begin
            $display("FAIL req027: digit 1 seg=%h, required 00", seg);
            n_fail++;
        end

        score = 4'd3;
        wait_frame();
        run(4 * RD, "req028a");
        wait_idx(2, 1);
        score = 4'd8;
        wait_idx(3, 1);
        n_tests++;
        if (frame_tick !== 1'b0) begin
            $display("FAIL req028: frame_tick=%b mid-frame, required 0", frame_tick);
            n_fail++;
        end
        wait_frame();
        n_tests++;
        if (frame_tick !== 1'b1 || seg !== 7'h7F) begin
            $display("FAIL req028: at wrap tick=%b seg=%h, required 1 7F", frame_tick, seg);
            n_fail++;
        end
        run(4 * RD, "req028b");

        score10 = 4'd4;
        score   = 4'd2;
        wait_frame();
        score10 = 4'd1;
        score   = 4'd5;
        run(8 * RD, "req029");
        n_tests++;
        if ({best10, best} !== {4'd4, 4'd2}) begin
            $display("FAIL req029: best=%0d%0d, required 42", best10, best);
            n_fail++;
        end

        score10 = 4'd0;
        score   = 4'd12;
        wait_frame();
        n_tests++;
        if (seg !== 7'h40) begin
            $display("FAIL req030: digit 0 seg=%h, required 40", seg);
            n_fail++;
        end
        run(4 * RD, "req030");
        n_tests++;
        if ({best10, best} !== {4'd4, 4'd2}) begin
            $display("FAIL req030: best=%0d%0d, required 42", best10, best);
            n_fail++;
        end

        score10 = 4'd9;
        score   = 4'd9;
        wait_frame();
        run(2 * RD, "req031a");
        n_tests++;
        if ({best10, best} !== {4'd9, 4'd9}) begin
            $display("FAIL req031: best=%0d%0d, required 99", best10, best);
            n_fail++;
        end
        wait_idx(2, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({best10, best, an, seg} !== {4'd0, 4'd0, 4'b0001, 7'h3F}) begin
            $display("FAIL req031: after reset best=%0d%0d an=%b seg=%h, required 00 0001 3F",
                     best10, best, an, seg);
            n_fail++;
        end
        run(RD - 1, "req031b");
        n_tests++;
        if (an !== 4'b0001) begin
            $display("FAIL req031: an=%b before advance, required 0001", an);
            n_fail++;
        end
        tick();
        n_tests++;
        if (an !== 4'b0010) begin
            $display("FAIL req031: an=%b at advance, required 0010", an);
            n_fail++;
        end
        run(8 * RD, "req031c");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
